mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped timer peripheral on the CPU data port. It responds to the data-side accesses the pipelined MIPS core initiates with memwrite, memaddr and memwritedata, and returns memreaddata.
- Provides a prescaled down-counter with one-shot and auto-reload modes, a sticky expiry flag and an interrupt line.
- The system top muxes its memreaddata with data memory using hit.

Parameters:
- BASE, 32'hFFFF0000, window base address; bits [4:0] must be zero; the window is 32 bytes.
- PRESC_W, 8, width of the prescale divider register and prescale counter.
- ID, 32'h54494D31, constant returned by the ID register.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- memwrite  input  1  CPU store strobe, valid in the CPU MEM stage
- memaddr  input  32  CPU byte address
- memwritedata  input  32  CPU store data
- memreaddata  output  32  read data, combinational from registered state and memaddr
- hit  output  1  memaddr[31:5] == BASE[31:5]
- irq  output  1  STATUS.exp & CTRL.ie

Behaviour:
- Timing, reset, decode:
  - One clock domain (clk). reset is synchronous and active-high. All state updates occur on the rising edge of clk.
  - Reset values: CTRL=0, LOAD=0, COUNT=0, PRESC=0, pcnt=0, STATUS=0, state=STOPPED. So after reset, irq=0, and memreaddata=0 unless the current address selects ID.
  - Word offset = memaddr[4:2]. memaddr[1:0] are ignored.
  - A write occurs only when memwrite & hit. A write in the same cycle that a read is presented has no effect on that cycle's read data; there is no bypass.
- Register map (offset: name, access):
  - 0x00 CTRL, RW: bit0 en, bit1 reload, bit2 ie. Upper bits read 0.
  - 0x04 LOAD, RW, 32 bits.
  - 0x08 COUNT, RW, 32 bits.
  - 0x0C STATUS: bit0 exp, write-1-to-clear. Read returns {31'b0, exp}.
  - 0x10 PRESC, RW, PRESC_W bits, zero-extended on read.
  - 0x14 ID, read-only. Writes are ignored.
  - 0x18 and 0x1C: reserved. Reads return 0; writes are ignored.
  - hit=0: memreaddata=0.
- State machine states: STOPPED, RUNNING, DONE. CTRL.en reads 1 only in RUNNING.
  - STOPPED/DONE -> RUNNING: on a CTRL write with bit0=1. Same edge: COUNT<=LOAD, pcnt<=0.
  - RUNNING -> STOPPED: on a CTRL write with bit0=0. COUNT holds its value.
  - RUNNING -> RUNNING: on a CTRL write with bit0=1. Only reload and ie update; COUNT and pcnt are untouched.
  - RUNNING -> DONE: on an expiry event with reload=0.
- Prescaler and counting (RUNNING only):
  - pcnt increments each cycle. When pcnt == PRESC, a tick fires and pcnt<=0. PRESC=0 gives a tick every cycle.
  - On a tick with COUNT != 0: COUNT<=COUNT-1.
  - On a tick with COUNT == 0 (expiry event): exp<=1. With reload=1, COUNT<=LOAD and the state stays RUNNING. With reload=0, COUNT stays 0 and the state goes to DONE.
  - Expiry period = (LOAD+1)*(PRESC+1) cycles. LOAD=0 expires on every tick.
  - In STOPPED/DONE: pcnt holds and no ticks fire.
- Simultaneous events:
  - A COUNT write on a tick edge: the write wins and the decrement/reload is discarded. pcnt behaves normally.
  - A STATUS W1C on an expiry edge: set wins, so exp=1.
  - A PRESC write: takes effect from the next cycle's comparison. pcnt is not cleared. If the new PRESC < pcnt, pcnt counts up through 2^PRESC_W wrap-around to reach PRESC; this is accepted behaviour.
  - A LOAD write on a reload edge: the old LOAD value is used.
- Reset mid-count: returns every register and the state to reset values on that edge. irq drops the cycle after that edge.
- irq is derived only from registered bits and has no combinational path from bus inputs.

Test Plan:
1. Reset, then read offsets 0x00..0x1C at BASE -> 0,0,0,0,0,0x54494D31,0,0. Read of BASE+0x40 -> hit=0, data 0.
2. LOAD=3, PRESC=0, CTRL=0x5 (one-shot, ie) -> COUNT reads 3,2,1,0 on successive cycles. exp=1 and irq=1 four cycles after the enable edge. CTRL reads 0x4 and COUNT stays 0.
3. LOAD=2, PRESC=1, CTRL=0x7 -> exp asserts every 6 cycles. W1C STATUS=1 clears exp; a write of 0 leaves it set. COUNT sequence is 2,2,1,1,0,0,2.
4. Write STATUS=1 on the exact expiry edge -> exp remains 1. Write COUNT=10 on a tick edge -> COUNT reads 10 next cycle.
5. Running with LOAD=100; write CTRL=0 at COUNT=57 -> COUNT holds 57 indefinitely. Write CTRL=1 -> COUNT reloads 100.
6. Assert reset while RUNNING with exp=1 -> next cycle all registers read 0, irq=0, and no further ticks.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled down-counter timer with one-shot/auto-reload, sticky expiry flag and irq.
// Latency: reads are combinational from registered state, writes land on the next clk edge; no backpressure, always ready.
module mmio_timer #(
  parameter logic [31:0] BASE    = 32'hFFFF0000,
  parameter int          PRESC_W = 8,
  parameter logic [31:0] ID      = 32'h54494D31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {STOPPED, RUNNING, DONE} state_t;

  typedef struct packed {
    logic ie;
    logic reload;
  } ctrl_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;
  localparam logic [2:0] OFF_ID     = 3'd5;

  state_t               state_q, state_d;
  ctrl_t                ctrl_q;
  logic [31:0]          load_q;
  logic [31:0]          count_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   pcnt_q;
  logic                 exp_q;

  logic [2:0] off;
  logic       wr, wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
  logic       start, stop, counting, tick, expire;
  logic       addr_lsb_unused;

  assign hit             = (memaddr[31:5] == BASE[31:5]);
  assign off             = memaddr[4:2];
  assign addr_lsb_unused = ^memaddr[1:0];

  assign wr        = memwrite & hit;
  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_load   = wr && (off == OFF_LOAD);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_status = wr && (off == OFF_STATUS);
  assign wr_presc  = wr && (off == OFF_PRESC);

  assign start    = wr_ctrl &&  memwritedata[0] && (state_q != RUNNING);
  assign stop     = wr_ctrl && !memwritedata[0] && (state_q == RUNNING);
  // A stop write freezes COUNT and pcnt on its own edge, so no tick lands there.
  assign counting = (state_q == RUNNING) && !stop;
  assign tick     = counting && (pcnt_q == presc_q);
  assign expire   = tick && (count_q == 32'd0);

  assign irq = exp_q & ctrl_q.ie;

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED, DONE: begin
        if (wr_ctrl && memwritedata[0]) state_d = RUNNING;
      end
      RUNNING: begin
        if (wr_ctrl)                          state_d = memwritedata[0] ? RUNNING : STOPPED;
        else if (expire && !ctrl_q.reload)    state_d = DONE;
      end
      default: state_d = STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= STOPPED;
      ctrl_q.ie     <= 1'b0;
      ctrl_q.reload <= 1'b0;
      load_q        <= '0;
      count_q       <= '0;
      presc_q       <= '0;
      pcnt_q        <= '0;
      exp_q         <= 1'b0;
    end else begin
      state_q <= state_d;

      if (wr_ctrl) begin
        ctrl_q.ie     <= memwritedata[2];
        ctrl_q.reload <= memwritedata[1];
      end
      if (wr_load)  load_q  <= memwritedata;
      if (wr_presc) presc_q <= memwritedata[PRESC_W-1:0];

      if (start)         pcnt_q <= '0;
      else if (counting) pcnt_q <= tick ? '0 : pcnt_q + 1'b1;

      // Bus writes to COUNT override any decrement or reload on the same edge.
      if (wr_count)   count_q <= memwritedata;
      else if (start) count_q <= load_q;
      else if (tick) begin
        if (count_q != 32'd0)   count_q <= count_q - 32'd1;
        else if (ctrl_q.reload) count_q <= load_q;
      end

      if (expire)                           exp_q <= 1'b1;
      else if (wr_status && memwritedata[0]) exp_q <= 1'b0;
    end
  end

  always_comb begin
    memreaddata = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:   memreaddata = {29'd0, ctrl_q.ie, ctrl_q.reload, state_q == RUNNING};
        OFF_LOAD:   memreaddata = load_q;
        OFF_COUNT:  memreaddata = count_q;
        OFF_STATUS: memreaddata = {31'd0, exp_q};
        OFF_PRESC:  memreaddata = {{(32-PRESC_W){1'b0}}, presc_q};
        OFF_ID:     memreaddata = ID;
        default:    memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register map, one-shot, auto-reload, write/event collisions, stop/hold, reset.
module tb_mmio_timer;

  localparam logic [31:0] BASE     = 32'hFFFF0000;
  localparam logic [31:0] ID       = 32'h54494D31;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;
  localparam logic [31:0] A_ID     = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        hit;
  logic        irq;

  int vectors    = 0;
  int miscompares = 0;

  mmio_timer #(.BASE(BASE), .PRESC_W(8), .ID(ID)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .hit          (hit),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr = a; memwritedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    memaddr = a; #1;
  endtask

  task automatic test_reset();
    logic [31:0] expv;
    reset = 1'b1; memwrite = 1'b0; memaddr = '0; memwritedata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(4 * i));
      expv = (i == 5) ? ID : 32'd0;
      vectors++;
      if (memreaddata !== expv || hit !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_read off=%0d: got %h hit=%b, expected %h hit=1", i, memreaddata, hit, expv);
      end
      cyc();
    end
    rd(BASE + 32'h40);
    vectors++;
    if (hit !== 1'b0 || memreaddata !== 32'd0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL outside_window: got hit=%b data=%h irq=%b, expected 0 0 0", hit, memreaddata, irq);
    end
    rd(BASE + 32'h16);
    vectors++;
    if (memreaddata !== ID) begin
      miscompares++;
      $display("FAIL id_lsb_ignored: got %h, expected %h", memreaddata, ID);
    end
    wr(BASE + 32'h18, 32'hDEADBEEF);
    wr(A_ID, 32'h0);
    wr(BASE + 32'h40, 32'h7);
    rd(BASE + 32'h18);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL reserved_write: got %h, expected 0", memreaddata);
    end
    rd(A_ID);
    vectors++;
    if (memreaddata !== ID) begin
      miscompares++;
      $display("FAIL id_write_ignored: got %h, expected %h", memreaddata, ID);
    end
    rd(A_CTRL);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL miss_write_ignored: got ctrl %h, expected 0", memreaddata);
    end
    cyc();
  endtask

  task automatic test_oneshot();
    wr(A_LOAD, 32'd3);
    wr(A_PRESC, 32'd0);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) begin
      rd(A_COUNT);
      vectors++;
      if (memreaddata !== 32'(3 - i) || irq !== 1'b0) begin
        miscompares++;
        $display("FAIL oneshot_count step=%0d: got %0d irq=%b, expected %0d irq=0", i, memreaddata, irq, 3 - i);
      end
      cyc();
    end
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL oneshot_expire: got status=%h irq=%b, expected 1 1", memreaddata, irq);
    end
    repeat (3) cyc();
    rd(A_CTRL);
    vectors++;
    if (memreaddata !== 32'h4) begin
      miscompares++;
      $display("FAIL oneshot_ctrl: got %h, expected 4", memreaddata);
    end
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL oneshot_hold: got %0d, expected 0", memreaddata);
    end
    wr(A_STATUS, 32'd1);
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_clear: got status=%h irq=%b, expected 0 0", memreaddata, irq);
    end
  endtask

  task automatic test_autoreload();
    int seq [7] = '{2, 2, 1, 1, 0, 0, 2};
    logic [31:0] expv;
    wr(A_LOAD, 32'd2);
    wr(A_PRESC, 32'd1);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 7; i++) begin
      rd(A_COUNT);
      vectors++;
      if (memreaddata !== 32'(seq[i])) begin
        miscompares++;
        $display("FAIL reload_count step=%0d: got %0d, expected %0d", i, memreaddata, seq[i]);
      end
      rd(A_STATUS);
      expv = (i == 6) ? 32'd1 : 32'd0;
      vectors++;
      if (memreaddata !== expv) begin
        miscompares++;
        $display("FAIL reload_exp step=%0d: got %h, expected %h", i, memreaddata, expv);
      end
      cyc();
    end
    wr(A_STATUS, 32'd1);
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL reload_w1c: got %h, expected 0", memreaddata);
    end
    repeat (3) cyc();
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL reload_early: got %h, expected 0", memreaddata);
    end
    cyc();
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_period: got status=%h irq=%b, expected 1 1", memreaddata, irq);
    end
    wr(A_STATUS, 32'd0);
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd1) begin
      miscompares++;
      $display("FAIL w0_no_clear: got %h, expected 1", memreaddata);
    end
  endtask

  // Continues the auto-reload run: expiries land on edges 18, 24, ... counted from the enable.
  task automatic test_collisions();
    wr(A_STATUS, 32'd1);
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL collide_preclear: got %h, expected 0", memreaddata);
    end
    repeat (3) cyc();
    wr(A_STATUS, 32'd1);
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd1) begin
      miscompares++;
      $display("FAIL w1c_vs_expire: got %h, expected 1", memreaddata);
    end
    cyc();
    wr(A_COUNT, 32'd10);
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd10) begin
      miscompares++;
      $display("FAIL count_wr_on_tick: got %0d, expected 10", memreaddata);
    end
    cyc();
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd10) begin
      miscompares++;
      $display("FAIL count_wr_hold: got %0d, expected 10", memreaddata);
    end
    cyc();
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd9) begin
      miscompares++;
      $display("FAIL count_wr_tick: got %0d, expected 9", memreaddata);
    end
  endtask

  task automatic test_stop_hold();
    wr(A_CTRL, 32'h0);
    wr(A_PRESC, 32'd0);
    wr(A_LOAD, 32'd100);
    wr(A_CTRL, 32'h1);
    repeat (43) cyc();
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd57) begin
      miscompares++;
      $display("FAIL stop_precount: got %0d, expected 57", memreaddata);
    end
    wr(A_CTRL, 32'h0);
    repeat (20) cyc();
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd57) begin
      miscompares++;
      $display("FAIL stop_hold: got %0d, expected 57", memreaddata);
    end
    rd(A_CTRL);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL stop_ctrl: got %h, expected 0", memreaddata);
    end
    wr(A_CTRL, 32'h1);
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd100) begin
      miscompares++;
      $display("FAIL restart_reload: got %0d, expected 100", memreaddata);
    end
    cyc();
    rd(A_COUNT);
    vectors++;
    if (memreaddata !== 32'd99) begin
      miscompares++;
      $display("FAIL restart_tick: got %0d, expected 99", memreaddata);
    end
  endtask

  task automatic test_reset_mid();
    wr(A_CTRL, 32'h0);
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h7);
    repeat (2) cyc();
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL premid_exp: got status=%h irq=%b, expected 1 1", memreaddata, irq);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b, expected 0", irq);
    end
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 32'(4 * i));
      vectors++;
      if (memreaddata !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_mid_reg off=%0d: got %h, expected 0", i, memreaddata);
      end
    end
    repeat (5) cyc();
    rd(A_STATUS);
    vectors++;
    if (memreaddata !== 32'd0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_tick: got status=%h irq=%b, expected 0 0", memreaddata, irq);
    end
    rd(A_CTRL);
    vectors++;
    if (memreaddata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stopped: got ctrl %h, expected 0", memreaddata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_collisions();
    test_stop_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
